// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes MIPS opcode/funct into a 3-bit ALU op with operands and
// buffers the result in a 2-entry skid buffer. Define ALU_ISSUE_FWD_EN for operand forwarding.
`timescale 1ns/1ps
module alu_issue_stage #(
   parameter int DEPTH     = 2,
   parameter int LUI_SHAMT = 16
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        FLUSH,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [5:0]  OPCODE,
   input  logic [5:0]  FUNCT,
   input  logic [4:0]  SHAMT,
   input  logic [15:0] IMM16,
   input  logic [4:0]  RT_IDX,
   input  logic [4:0]  RD_IDX,
   input  logic [31:0] RS_VAL,
   input  logic [31:0] RT_VAL,
`ifdef ALU_ISSUE_FWD_EN
   input  logic [4:0]  RS_IDX,
   input  logic        FWD_VALID,
   input  logic [4:0]  FWD_DEST,
   input  logic [31:0] FWD_DATA,
`endif
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic [31:0] ALU_A,
   output logic [31:0] ALU_B,
   output logic [2:0]  ALU_OP,
   output logic        TRAP_OV,
   output logic        ILLEGAL,
   output logic [4:0]  DEST,
   output logic        WE
);

   typedef enum logic [2:0] {
      OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SLTU, OP_SLL
   } alu_op_e;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      alu_op_e     op;
      logic        trap;
      logic        illegal;
      logic [4:0]  dest;
      logic        we;
   } entry_t;

   localparam logic [1:0] FULL = 2'(DEPTH);

   entry_t [1:0] ent_q, ent_d;
   entry_t       dec;
   logic [1:0]   count_q, count_d;
   logic         in_ready_q, in_ready_d;
   logic [31:0]  rs_v, rt_v, imm_se, imm_ze;
   logic         legal, accept, deq;

   assign imm_se = {{16{IMM16[15]}}, IMM16};
   assign imm_ze = {16'h0000, IMM16};

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      rs_v = RS_VAL;
      rt_v = RT_VAL;
`ifdef ALU_ISSUE_FWD_EN
      if (FWD_VALID && FWD_DEST != 5'd0) begin
         if (FWD_DEST == RS_IDX) rs_v = FWD_DATA;
         if (FWD_DEST == RT_IDX) rt_v = FWD_DATA;
      end
`endif
   end

   always_comb begin
      dec   = '0;
      legal = 1'b1;
      dec.a = rs_v;
      if (OPCODE == 6'h00) begin
         dec.b    = rt_v;
         dec.dest = RD_IDX;
         case (FUNCT)
            6'h20: begin dec.op = OP_ADD; dec.trap = 1'b1; end
            6'h21: dec.op = OP_ADD;
            6'h22: begin dec.op = OP_SUB; dec.trap = 1'b1; end
            6'h23: dec.op = OP_SUB;
            6'h24: dec.op = OP_AND;
            6'h25: dec.op = OP_OR;
            6'h26: dec.op = OP_XOR;
            6'h27: dec.op = OP_NOR;
            6'h2B: dec.op = OP_SLTU;
            6'h00: begin dec.op = OP_SLL; dec.a = {27'b0, SHAMT}; end
            6'h04: begin dec.op = OP_SLL; dec.a = {27'b0, rs_v[4:0]}; end
            default: legal = 1'b0;
         endcase
      end else begin
         dec.dest = RT_IDX;
         case (OPCODE)
            6'h08: begin dec.op = OP_ADD;  dec.b = imm_se; dec.trap = 1'b1; end
            6'h09: begin dec.op = OP_ADD;  dec.b = imm_se; end
            6'h0B: begin dec.op = OP_SLTU; dec.b = imm_se; end
            6'h0C: begin dec.op = OP_AND;  dec.b = imm_ze; end
            6'h0D: begin dec.op = OP_OR;   dec.b = imm_ze; end
            6'h0E: begin dec.op = OP_XOR;  dec.b = imm_ze; end
            6'h0F: begin dec.op = OP_SLL;  dec.b = imm_ze; dec.a = 32'(LUI_SHAMT); end
            default: legal = 1'b0;
         endcase
      end
      if (!legal) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end else begin
         dec.we = (dec.dest != 5'd0);
      end
   end

   assign accept = IN_VALID && in_ready_q;
   assign deq    = OUT_VALID && OUT_READY;

   // Entry 0 is always the head; entry 1 only shifts up when it actually holds data.
   always_comb begin
      ent_d   = ent_q;
      count_d = count_q;
      if (FLUSH) begin
         count_d = 2'd0;
      end else begin
         case ({accept, deq})
            2'b10: begin
               ent_d[count_q[0]] = dec;
               count_d           = count_q + 2'd1;
            end
            2'b01: begin
               if (count_q == 2'd2) ent_d[0] = ent_q[1];
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd2) begin
                  ent_d[0] = ent_q[1];
                  ent_d[1] = dec;
               end else begin
                  ent_d[0] = dec;
               end
            end
            default: ;
         endcase
      end
      in_ready_d = (count_d < FULL);
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: the buffer storage is reset too, because every data output must read zero after reset.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ent_q      <= '0;
         count_q    <= 2'd0;
         in_ready_q <= 1'b1;
      end else begin
         ent_q      <= ent_d;
         count_q    <= count_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = (count_q != 2'd0);
   assign ALU_A     = ent_q[0].a;
   assign ALU_B     = ent_q[0].b;
   assign ALU_OP    = ent_q[0].op;
   assign TRAP_OV   = ent_q[0].trap;
   assign ILLEGAL   = ent_q[0].illegal;
   assign DEST      = ent_q[0].dest;
   assign WE        = ent_q[0].we;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: a reference decoder pushes expected entries on
// acceptance; the head is compared every cycle it is valid and popped on OUT_READY.
`timescale 1ns/1ps
module tb_alu_issue_stage;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        FLUSH = 1'b0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [5:0]  OPCODE = '0;
   logic [5:0]  FUNCT = '0;
   logic [4:0]  SHAMT = '0;
   logic [15:0] IMM16 = '0;
   logic [4:0]  RT_IDX = '0;
   logic [4:0]  RD_IDX = '0;
   logic [31:0] RS_VAL = '0;
   logic [31:0] RT_VAL = '0;
`ifdef ALU_ISSUE_FWD_EN
   logic [4:0]  RS_IDX = '0;
   logic        FWD_VALID = 1'b0;
   logic [4:0]  FWD_DEST = '0;
   logic [31:0] FWD_DATA = '0;
`endif
   logic        OUT_VALID;
   logic        OUT_READY = 1'b0;
   logic [31:0] ALU_A, ALU_B;
   logic [2:0]  ALU_OP;
   logic        TRAP_OV, ILLEGAL, WE;
   logic [4:0]  DEST;

   alu_issue_stage dut (
      .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .OPCODE(OPCODE), .FUNCT(FUNCT), .SHAMT(SHAMT), .IMM16(IMM16),
      .RT_IDX(RT_IDX), .RD_IDX(RD_IDX), .RS_VAL(RS_VAL), .RT_VAL(RT_VAL),
`ifdef ALU_ISSUE_FWD_EN
      .RS_IDX(RS_IDX), .FWD_VALID(FWD_VALID), .FWD_DEST(FWD_DEST), .FWD_DATA(FWD_DATA),
`endif
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .TRAP_OV(TRAP_OV),
      .ILLEGAL(ILLEGAL), .DEST(DEST), .WE(WE)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic        trap;
      logic        ill;
      logic [4:0]  dest;
      logic        we;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decoder built from the instruction fields currently driven.
   function automatic exp_t model();
      exp_t        e = '0;
      logic [31:0] rs = RS_VAL;
      logic [31:0] rt = RT_VAL;
      logic [31:0] se = {{16{IMM16[15]}}, IMM16};
      logic [31:0] ze = {16'h0, IMM16};
      bit          ok = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
      if (FWD_VALID && FWD_DEST != 0 && FWD_DEST == RS_IDX) rs = FWD_DATA;
      if (FWD_VALID && FWD_DEST != 0 && FWD_DEST == RT_IDX) rt = FWD_DATA;
`endif
      if (OPCODE == 0) begin
         e.a = rs; e.b = rt; e.dest = RD_IDX;
         case (FUNCT)
            6'h20: begin e.op = 4; e.trap = 1; end
            6'h21: e.op = 4;
            6'h22: begin e.op = 5; e.trap = 1; end
            6'h23: e.op = 5;
            6'h24: e.op = 0;
            6'h25: e.op = 1;
            6'h26: e.op = 2;
            6'h27: e.op = 3;
            6'h2B: e.op = 6;
            6'h00: begin e.op = 7; e.a = 32'(SHAMT); end
            6'h04: begin e.op = 7; e.a = rs & 32'h1F; end
            default: ok = 0;
         endcase
      end else begin
         e.a = rs; e.dest = RT_IDX;
         case (OPCODE)
            6'h08: begin e.op = 4; e.b = se; e.trap = 1; end
            6'h09: begin e.op = 4; e.b = se; end
            6'h0B: begin e.op = 6; e.b = se; end
            6'h0C: begin e.op = 0; e.b = ze; end
            6'h0D: begin e.op = 1; e.b = ze; end
            6'h0E: begin e.op = 2; e.b = ze; end
            6'h0F: begin e.op = 7; e.b = ze; e.a = 32'd16; end
            default: ok = 0;
         endcase
      end
      if (!ok) begin
         e = '0;
         e.ill = 1;
      end else begin
         e.we = (e.dest != 0);
      end
      return e;
   endfunction

   task automatic check_head(input exp_t e);
      check("alu_a",   ALU_A, e.a);
      check("alu_b",   ALU_B, e.b);
      check("alu_op",  32'(ALU_OP), 32'(e.op));
      check("trap_ov", 32'(TRAP_OV), 32'(e.trap));
      check("illegal", 32'(ILLEGAL), 32'(e.ill));
      if (!e.ill) check("dest", 32'(DEST), 32'(e.dest));
      check("we",      32'(WE), 32'(e.we));
   endtask

   // Called at the falling edge with inputs already driven; advances one cycle.
   task automatic tick();
      bit exp_rdy = (sb.size() < 2);
      check("out_valid", 32'(OUT_VALID), 32'(sb.size() != 0));
      check("in_ready",  32'(IN_READY),  32'(exp_rdy));
      if (sb.size() != 0) begin
         check_head(sb[0]);
         if (OUT_READY) void'(sb.pop_front());
      end
      if (IN_VALID && exp_rdy && !FLUSH) sb.push_back(model());
      if (FLUSH) sb.delete();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                            input logic [15:0] imm, input logic [4:0] rt_i, input logic [4:0] rd_i,
                            input logic [31:0] rs_v, input logic [31:0] rt_v);
      OPCODE = op; FUNCT = fn; SHAMT = sh; IMM16 = imm;
      RT_IDX = rt_i; RD_IDX = rd_i; RS_VAL = rs_v; RT_VAL = rt_v;
   endtask

   task automatic rand_instr();
      logic [5:0] ops[11] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A};
      logic [5:0] fns[13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2B, 6'h00, 6'h04, 6'h2A, 6'h3F};
      set_instr(ops[$urandom_range(10)], fns[$urandom_range(12)], 5'($urandom), 16'($urandom),
                5'($urandom), 5'($urandom), $urandom, $urandom);
   endtask

   initial begin
      logic [5:0] rfn[14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2B, 6'h00, 6'h04, 6'h2A, 6'h3F, 6'h08};
      logic [5:0] iop[9]  = '{6'h08, 6'h09, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h0A, 6'h02};

      // Reset state
      repeat (2) @(negedge CLK);
      check("rst_out_valid", 32'(OUT_VALID), 0);
      check("rst_in_ready",  32'(IN_READY), 1);
      check("rst_a", ALU_A, 0);
      check("rst_b", ALU_B, 0);
      check("rst_misc", {21'b0, ALU_OP, TRAP_OV, ILLEGAL, DEST, WE}, 0);
      RST_N = 1'b1;
      @(negedge CLK);

      // addi with sign-extended immediate
      OUT_READY = 1'b1;
      IN_VALID  = 1'b1;
      set_instr(6'h08, 6'h00, 5'd0, 16'hFFFF, 5'd3, 5'd0, 32'd5, 32'd0);
      tick();
      IN_VALID = 1'b0;
      check("addi_valid", 32'(OUT_VALID), 1);
      check("addi_op",    32'(ALU_OP), 4);
      check("addi_a",     ALU_A, 32'd5);
      check("addi_b",     ALU_B, 32'hFFFFFFFF);
      check("addi_trap",  32'(TRAP_OV), 1);
      check("addi_dest",  32'(DEST), 3);
      check("addi_we",    32'(WE), 1);
      tick();

      // lui and ori
      IN_VALID = 1'b1;
      set_instr(6'h0F, 6'h00, 5'd0, 16'h1234, 5'd4, 5'd0, 32'hDEAD, 32'd0);
      tick();
      IN_VALID = 1'b0;
      check("lui_op", 32'(ALU_OP), 7);
      check("lui_a",  ALU_A, 32'd16);
      check("lui_b",  ALU_B, 32'h00001234);
      tick();
      IN_VALID = 1'b1;
      set_instr(6'h0D, 6'h00, 5'd0, 16'h8000, 5'd6, 5'd0, 32'h1, 32'd0);
      tick();
      IN_VALID = 1'b0;
      check("ori_op", 32'(ALU_OP), 1);
      check("ori_b",  ALU_B, 32'h00008000);
      tick();

      // slt is illegal; addu to r0 does not write back
      IN_VALID = 1'b1;
      set_instr(6'h00, 6'h2A, 5'd0, 16'h0, 5'd1, 5'd9, 32'h7, 32'h9);
      tick();
      IN_VALID = 1'b0;
      check("slt_ill",  32'(ILLEGAL), 1);
      check("slt_we",   32'(WE), 0);
      check("slt_trap", 32'(TRAP_OV), 0);
      tick();
      IN_VALID = 1'b1;
      set_instr(6'h00, 6'h21, 5'd0, 16'h0, 5'd1, 5'd0, 32'h7, 32'h9);
      tick();
      IN_VALID = 1'b0;
      check("addu_r0_we", 32'(WE), 0);
      tick();

      // Back-to-back sweep of R-type functs and I-type opcodes
      IN_VALID = 1'b1;
      foreach (rfn[i]) begin
         set_instr(6'h00, rfn[i], 5'(i + 3), 16'($urandom), 5'($urandom), 5'(i + 1), $urandom, $urandom);
         tick();
      end
      foreach (iop[i]) begin
         set_instr(iop[i], 6'h20, 5'd7, 16'($urandom), 5'(i + 2), 5'd0, $urandom, $urandom);
         tick();
      end
      IN_VALID = 1'b0;
      repeat (2) tick();

      // Back-pressure: three offered, two accepted, held stable, then drained in order
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_instr();
         tick();
      end
      IN_VALID = 1'b0;
      check("bp_in_ready", 32'(IN_READY), 0);
      repeat (2) tick();
      OUT_READY = 1'b1;
      repeat (3) tick();
      check("bp_drained", 32'(sb.size()), 0);

      // Flush with two entries held and a valid input offered
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      repeat (2) begin rand_instr(); tick(); end
      FLUSH = 1'b1;
      set_instr(6'h09, 6'h00, 5'd0, 16'h0042, 5'd5, 5'd0, 32'h99, 32'd0);
      tick();
      FLUSH = 1'b0;
      IN_VALID = 1'b0;
      check("flush_valid", 32'(OUT_VALID), 0);
      check("flush_ready", 32'(IN_READY), 1);
      OUT_READY = 1'b1;
      repeat (2) tick();

      // Random traffic including simultaneous accept and dequeue
      for (int c = 0; c < 300; c++) begin
         IN_VALID  = 1'($urandom_range(3) != 0);
         OUT_READY = 1'($urandom_range(2) != 0);
         rand_instr();
         tick();
      end
      IN_VALID  = 1'b0;
      OUT_READY = 1'b1;
      repeat (3) tick();
      check("rand_drained", 32'(sb.size()), 0);

      // Asynchronous reset mid-cycle with one entry held
      OUT_READY = 1'b0;
      IN_VALID  = 1'b1;
      rand_instr();
      tick();
      IN_VALID = 1'b0;
      #2 RST_N = 1'b0;
      #1;
      check("arst_valid", 32'(OUT_VALID), 0);
      check("arst_ready", 32'(IN_READY), 1);
      check("arst_a",     ALU_A, 0);
      sb.delete();
      @(negedge CLK);
      RST_N = 1'b1;
      OUT_READY = 1'b1;
      repeat (2) tick();

`ifdef ALU_ISSUE_FWD_EN
      // Forwarding onto rs, then onto both rs and rt
      IN_VALID  = 1'b1;
      FWD_VALID = 1'b1;
      FWD_DEST  = 5'd7;
      FWD_DATA  = 32'hAA;
      RS_IDX    = 5'd7;
      set_instr(6'h00, 6'h21, 5'd0, 16'h0, 5'd8, 5'd2, 32'h1, 32'h2);
      tick();
      IN_VALID = 1'b0;
      check("fwd_a", ALU_A, 32'hAA);
      check("fwd_b", ALU_B, 32'h2);
      tick();
      IN_VALID = 1'b1;
      set_instr(6'h00, 6'h26, 5'd0, 16'h0, 5'd7, 5'd2, 32'h1, 32'h2);
      tick();
      IN_VALID  = 1'b0;
      FWD_VALID = 1'b0;
      check("fwd_both_b", ALU_B, 32'hAA);
      repeat (2) tick();
`endif

      check("final_empty", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the 3-bit-opcode ALU.
- Decodes the MIPS opcode/funct into ALU_OP (0 and, 1 or, 2 xor, 3 nor, 4 add, 5 sub, 6 slt unsigned, 7 sll as B<<A) and selects the A/B operands.
- Registers the result behind a 2-entry valid/ready skid buffer, so decode back-pressure never forms a combinational path.
- Also emits overflow-trap enable, illegal-instruction and writeback-destination info for the stage that consumes ALU F/OF.

Parameters:
- DEPTH, 2, skid buffer entries; only 2 is supported.
- LUI_SHAMT, 16, shift amount applied for LUI.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- FLUSH  in  1  synchronous flush of all buffered entries
- IN_VALID  in  1  decoded instruction present
- IN_READY  out  1  stage can accept this cycle
- OPCODE  in  6  instr[31:26]
- FUNCT  in  6  instr[5:0]
- SHAMT  in  5  instr[10:6]
- IMM16  in  16  instr[15:0]
- RT_IDX  in  5  instr[20:16]
- RD_IDX  in  5  instr[15:11]
- RS_VAL  in  32  rs register value
- RT_VAL  in  32  rt register value
- OUT_VALID  out  1  head entry valid
- OUT_READY  in  1  ALU/EX consumer accepts head
- ALU_A  out  32  operand A
- ALU_B  out  32  operand B
- ALU_OP  out  3  ALU operation
- TRAP_OV  out  1  consumer must raise exception on OF
- ILLEGAL  out  1  unsupported encoding
- DEST  out  5  writeback register
- WE  out  1  writeback enable: !ILLEGAL && DEST!=0

Behaviour:
- Reset (RST_N=0, async): both entries invalid; OUT_VALID=0, IN_READY=1, every data output = 0. RST_N is asserted mid-transfer: the in-flight instruction is lost, with no partial output.
- Decode is combinational and is captured on acceptance (IN_VALID && IN_READY).
- R-type (OPCODE=0), A=RS_VAL, B=RT_VAL, DEST=RD_IDX:
  - FUNCT 20 add: op4, trap.
  - FUNCT 21 addu: op4.
  - FUNCT 22 sub: op5, trap.
  - FUNCT 23 subu: op5.
  - FUNCT 24 and: op0. FUNCT 25 or: op1. FUNCT 26 xor: op2. FUNCT 27 nor: op3.
  - FUNCT 2B sltu: op6.
  - FUNCT 00 sll: op7, A = zero-extended SHAMT.
  - FUNCT 04 sllv: op7, A = {27'b0, RS_VAL[4:0]}.
- I-type, A=RS_VAL, DEST=RT_IDX:
  - Sign-extended imm: 08 addi (op4, trap), 09 addiu (op4), 0B sltiu (op6).
  - Zero-extended imm: 0C andi (op0), 0D ori (op1), 0E xori (op2).
  - 0F lui: op7, A=LUI_SHAMT, B = zero-extended IMM16.
- Any other encoding, including slt (FUNCT 2A) and slti (0A): ILLEGAL=1, ALU_OP=0, A=B=0, TRAP_OV=0, WE=0. The entry still flows through the buffer.
- Latency: an entry accepted in cycle N is presented with OUT_VALID=1 in cycle N+1 at the earliest.
- Head outputs hold stable while OUT_VALID && !OUT_READY.
- FIFO order is strict.
- IN_READY is registered: 1 iff fewer than 2 entries are held after the current cycle's updates.
- Accept and dequeue in the same cycle: occupancy unchanged; the entry moves up.
- Full (2 entries) with OUT_READY=0: IN_READY=0; IN_VALID is ignored.
- Empty: OUT_VALID=0; outputs keep their last values, and only OUT_VALID is meaningful.
- FLUSH=1: at the next edge both entries are invalidated. An input accepted in the same cycle is dropped (flush wins). IN_READY=1 in the following cycle.
- No arithmetic is performed here. Sign extension is IMM16[15] replicated into bits 31:16.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- When defined, add these ports:
  - RS_IDX in 5.
  - FWD_VALID in 1.
  - FWD_DEST in 5.
  - FWD_DATA in 32.
- At capture, if FWD_VALID && FWD_DEST!=0:
  - FWD_DEST==RS_IDX: FWD_DATA replaces RS_VAL.
  - FWD_DEST==RT_IDX: FWD_DATA replaces RT_VAL.
  - Both are substituted when both match.
- Forwarding never changes entries already buffered.
- When undefined, these ports do not exist, and operands come only from RS_VAL/RT_VAL.

Test Plan:
- Reset then addi: OPCODE=08, IMM16=FFFF, RS_VAL=5, RT_IDX=3 -> next cycle OUT_VALID=1, ALU_OP=4, A=5, B=FFFFFFFF, TRAP_OV=1, DEST=3, WE=1.
- lui: OPCODE=0F, IMM16=1234 -> ALU_OP=7, A=16, B=00001234. ori IMM16=8000 -> B=00008000, ALU_OP=1.
- Back-pressure: OUT_READY=0 with 3 back-to-back valid inputs -> IN_READY falls after 2 accepts; outputs stable; OUT_READY=1 then drains in order with no loss or duplication.
- FLUSH asserted with 2 entries held and IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, flushed input never appears.
- FUNCT=2A (slt) -> ILLEGAL=1, WE=0, TRAP_OV=0; rd=0 addu -> WE=0.
- RST_N pulsed low asynchronously mid-cycle with 1 entry held -> OUT_VALID=0 immediately. With ALU_ISSUE_FWD_EN: FWD_DEST=RS_IDX=7, FWD_DATA=AA -> A=AA.
